// File: rtl/mpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mpu_ctrl
// Description : Sequencer between the AXI-Stream command receiver and the
//               MMU/buffer datapath. Generates buffer write addresses for
//               matrix loads, records per-slot dimensions, checks operand
//               compatibility and runs the clear/feed/drain/readout schedule
//               of the systolic array.
// Revision    : 1.0 - initial release
// ============================================================================
module mpu_ctrl #(
    parameter int MMU_SIZE = 10,
    parameter int SLOTS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       buffer_a_b,
    input  logic [4:0] buffer_a_idx,
    input  logic [4:0] buffer_b_idx,
    input  logic [7:0] dim_x,
    input  logic [7:0] dim_y,
    input  logic       data_valid,
    input  logic       multiply,
    output logic       mpu_ready,
    output logic       wr_en,
    output logic       wr_sel,
    output logic [1:0] wr_idx,
    output logic [7:0] wr_row,
    output logic [7:0] wr_col,
    output logic       mmu_clear,
    output logic       rd_en,
    output logic [1:0] rd_a_idx,
    output logic [1:0] rd_b_idx,
    output logic [7:0] rd_k,
    output logic       acc_out_en,
    output logic [7:0] acc_row,
    output logic       done,
    output logic [7:0] ctrl_error
);

    // Drain length: last partial sum leaves the array 2*N-1 cycles after the
    // final operand enters.
    localparam logic [7:0] c_PIPE      = 8'(2 * MMU_SIZE - 1);
    localparam logic [7:0] c_ERR_NONE  = 8'h00;
    localparam logic [7:0] c_ERR_DIM   = 8'h02;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_CLEAR = 3'd2;
    localparam logic [2:0] c_FEED  = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;
    localparam logic [2:0] c_OUT   = 3'd5;
    localparam logic [2:0] c_DONE  = 3'd6;

    logic [2:0] r_state;

    // Load context
    logic       r_sel;
    logic [1:0] r_idx;
    logic [7:0] r_dim_x;
    logic [7:0] r_dim_y;
    logic [7:0] r_row;
    logic [7:0] r_col;

    // Multiply context
    logic [1:0] r_a_idx;
    logic [1:0] r_b_idx;
    logic [7:0] r_k_len;
    logic [7:0] r_m_len;
    logic [7:0] r_cnt;
    logic [7:0] r_err;

    // Recorded slot dimensions for both buffers
    logic [7:0] r_a_dx [SLOTS];
    logic [7:0] r_a_dy [SLOTS];
    logic [7:0] r_b_dx [SLOTS];
    logic [7:0] r_b_dy [SLOTS];

    logic [1:0] w_ld_idx;
    logic [7:0] w_a_cols;
    logic [7:0] w_a_rows;
    logic [7:0] w_b_rows;
    logic       w_mul_bad;
    logic       w_ld_accept;
    logic       w_ld_empty;
    logic       w_unused_idx_hi;

    // Upper slot-index bits are never used: the receiver keeps indices small.
    assign w_unused_idx_hi = ^{buffer_a_idx[4:2], buffer_b_idx[4:2], r_b_dx[0]};

    assign w_ld_idx    = buffer_a_b ? buffer_b_idx[1:0] : buffer_a_idx[1:0];
    assign w_ld_accept = (r_state == c_IDLE) && load;
    assign w_ld_empty  = (dim_x == 8'd0) || (dim_y == 8'd0);

    assign w_a_cols  = r_a_dx[buffer_a_idx[1:0]];
    assign w_a_rows  = r_a_dy[buffer_a_idx[1:0]];
    assign w_b_rows  = r_b_dy[buffer_b_idx[1:0]];
    assign w_mul_bad = (w_a_cols != w_b_rows) || (w_a_cols == 8'd0);

    // Slot dimension registers: written on every accepted load, even empty ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_a_dx[i] <= 8'd0;
                r_a_dy[i] <= 8'd0;
                r_b_dx[i] <= 8'd0;
                r_b_dy[i] <= 8'd0;
            end
        end else if (w_ld_accept) begin
            if (buffer_a_b) begin
                r_b_dx[w_ld_idx] <= dim_x;
                r_b_dy[w_ld_idx] <= dim_y;
            end else begin
                r_a_dx[w_ld_idx] <= dim_x;
                r_a_dy[w_ld_idx] <= dim_y;
            end
        end
    end

    // Main sequencer: state, element counters, phase counter and error code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_sel   <= 1'b0;
            r_idx   <= 2'd0;
            r_dim_x <= 8'd0;
            r_dim_y <= 8'd0;
            r_row   <= 8'd0;
            r_col   <= 8'd0;
            r_a_idx <= 2'd0;
            r_b_idx <= 2'd0;
            r_k_len <= 8'd0;
            r_m_len <= 8'd0;
            r_cnt   <= 8'd0;
            r_err   <= c_ERR_NONE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (load) begin
                        // Load has priority; a simultaneous multiply is dropped.
                        r_sel   <= buffer_a_b;
                        r_idx   <= w_ld_idx;
                        r_dim_x <= dim_x;
                        r_dim_y <= dim_y;
                        r_row   <= 8'd0;
                        r_col   <= 8'd0;
                        r_err   <= c_ERR_NONE;
                        if (!w_ld_empty) begin
                            r_state <= c_LOAD;
                        end
                    end else if (multiply) begin
                        if (w_mul_bad) begin
                            r_err <= c_ERR_DIM;
                        end else begin
                            r_a_idx <= buffer_a_idx[1:0];
                            r_b_idx <= buffer_b_idx[1:0];
                            r_k_len <= w_a_cols;
                            r_m_len <= w_a_rows;
                            r_cnt   <= 8'd0;
                            r_err   <= c_ERR_NONE;
                            r_state <= c_CLEAR;
                        end
                    end
                end
                c_LOAD: begin
                    // Row-major walk; gaps in data_valid hold the position.
                    if (data_valid) begin
                        if (r_col == r_dim_x - 8'd1) begin
                            r_col <= 8'd0;
                            if (r_row == r_dim_y - 8'd1) begin
                                r_row   <= 8'd0;
                                r_state <= c_IDLE;
                            end else begin
                                r_row <= r_row + 8'd1;
                            end
                        end else begin
                            r_col <= r_col + 8'd1;
                        end
                    end
                end
                c_CLEAR: begin
                    r_cnt   <= 8'd0;
                    r_state <= c_FEED;
                end
                c_FEED: begin
                    if (r_cnt == r_k_len - 8'd1) begin
                        r_cnt   <= 8'd0;
                        r_state <= c_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_DRAIN: begin
                    if (r_cnt == c_PIPE - 8'd1) begin
                        r_cnt <= 8'd0;
                        // A zero-row operand has nothing to read out.
                        r_state <= (r_m_len != 8'd0) ? c_OUT : c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_OUT: begin
                    if (r_cnt == r_m_len - 8'd1) begin
                        r_cnt   <= 8'd0;
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state; address fields are zero outside
    // the phase that uses them.
    assign mpu_ready  = (r_state == c_IDLE);
    assign wr_en      = (r_state == c_LOAD) && data_valid;
    assign wr_sel     = (r_state == c_LOAD) ? r_sel   : 1'b0;
    assign wr_idx     = (r_state == c_LOAD) ? r_idx   : 2'd0;
    assign wr_row     = (r_state == c_LOAD) ? r_row   : 8'd0;
    assign wr_col     = (r_state == c_LOAD) ? r_col   : 8'd0;
    assign mmu_clear  = (r_state == c_CLEAR);
    assign rd_en      = (r_state == c_FEED);
    assign rd_a_idx   = (r_state == c_FEED) ? r_a_idx : 2'd0;
    assign rd_b_idx   = (r_state == c_FEED) ? r_b_idx : 2'd0;
    assign rd_k       = (r_state == c_FEED) ? r_cnt   : 8'd0;
    assign acc_out_en = (r_state == c_OUT);
    assign acc_row    = (r_state == c_OUT)  ? r_cnt   : 8'd0;
    assign done       = (r_state == c_DONE);
    assign ctrl_error = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpu_ctrl
// Description : Directed self-checking bench for mpu_ctrl (MMU_SIZE=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpu_ctrl;

    logic       clk;
    logic       rst;
    logic       load;
    logic       buffer_a_b;
    logic [4:0] buffer_a_idx;
    logic [4:0] buffer_b_idx;
    logic [7:0] dim_x;
    logic [7:0] dim_y;
    logic       data_valid;
    logic       multiply;
    logic       mpu_ready;
    logic       wr_en;
    logic       wr_sel;
    logic [1:0] wr_idx;
    logic [7:0] wr_row;
    logic [7:0] wr_col;
    logic       mmu_clear;
    logic       rd_en;
    logic [1:0] rd_a_idx;
    logic [1:0] rd_b_idx;
    logic [7:0] rd_k;
    logic       acc_out_en;
    logic [7:0] acc_row;
    logic       done;
    logic [7:0] ctrl_error;

    int n_total;
    int n_bad;

    mpu_ctrl #(.MMU_SIZE(10), .SLOTS(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .buffer_a_b   (buffer_a_b),
        .buffer_a_idx (buffer_a_idx),
        .buffer_b_idx (buffer_b_idx),
        .dim_x        (dim_x),
        .dim_y        (dim_y),
        .data_valid   (data_valid),
        .multiply     (multiply),
        .mpu_ready    (mpu_ready),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_idx       (wr_idx),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .mmu_clear    (mmu_clear),
        .rd_en        (rd_en),
        .rd_a_idx     (rd_a_idx),
        .rd_b_idx     (rd_b_idx),
        .rd_k         (rd_k),
        .acc_out_en   (acc_out_en),
        .acc_row      (acc_row),
        .done         (done),
        .ctrl_error   (ctrl_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {mpu_ready, wr_en, mmu_clear, rd_en, acc_out_en, done}
    function automatic logic [5:0] strb();
        return {mpu_ready, wr_en, mmu_clear, rd_en, acc_out_en, done};
    endfunction

    task automatic start_load(input logic sel, input logic [4:0] idx,
                              input logic [7:0] dx, input logic [7:0] dy);
        load       = 1'b1;
        buffer_a_b = sel;
        if (sel) buffer_b_idx = idx;
        else     buffer_a_idx = idx;
        dim_x      = dx;
        dim_y      = dy;
        tick();
        load = 1'b0;
    endtask

    // Stream dx*dy elements; gaps inserts a dead cycle before every element after the first.
    task automatic stream(input string tag, input logic sel, input logic [1:0] idx,
                          input int dx, input int dy, input bit gaps);
        for (int i = 0; i < dx * dy; i++) begin
            if (gaps && i > 0) begin
                data_valid = 1'b0;
                #0;
                chk({tag, "_gap"}, {wr_en, wr_row, wr_col},
                    {1'b0, 8'(i / dx), 8'(i % dx)});
                tick();
            end
            data_valid = 1'b1;
            #0;
            chk({tag, "_wr"}, {mpu_ready, wr_en, wr_sel, wr_idx, wr_row, wr_col},
                {1'b0, 1'b1, sel, idx, 8'(i / dx), 8'(i % dx)});
            tick();
        end
        chk({tag, "_ready"}, {mpu_ready, wr_en}, {1'b1, 1'b0});
        data_valid = 1'b0;
    endtask

    int c;
    logic [5:0] exp_s;

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1; load = 1'b0; buffer_a_b = 1'b0; buffer_a_idx = 5'd0;
        buffer_b_idx = 5'd0; dim_x = 8'd0; dim_y = 8'd0; data_valid = 1'b0;
        multiply = 1'b0;
        tick();
        tick();
        chk("reset_strb", strb(), 6'b100000);
        chk("reset_err", ctrl_error, 8'h00);
        rst = 1'b0;
        tick();

        // A slot 0, 3 columns x 2 rows, continuous data
        start_load(1'b0, 5'd0, 8'd3, 8'd2);
        stream("ldA", 1'b0, 2'd0, 3, 2, 1'b0);
        tick();

        // Same load with a dead cycle between elements
        start_load(1'b0, 5'd0, 8'd3, 8'd2);
        stream("ldA_gap", 1'b0, 2'd0, 3, 2, 1'b1);
        tick();

        // B slot 1, 2 columns x 3 rows
        start_load(1'b1, 5'd1, 8'd2, 8'd3);
        stream("ldB", 1'b1, 2'd1, 2, 3, 1'b0);

        // Multiply A0 x B1: K=3, M=2, PIPE=19 -> 26 busy cycles
        buffer_a_idx = 5'd0;
        buffer_b_idx = 5'd1;
        multiply = 1'b1;
        tick();
        multiply = 1'b0;
        c = 0;
        while (!mpu_ready && c < 40) begin
            if (c == 0)       exp_s = 6'b001000;
            else if (c <= 3)  exp_s = 6'b000100;
            else if (c <= 22) exp_s = 6'b000000;
            else if (c <= 24) exp_s = 6'b000010;
            else              exp_s = 6'b000001;
            chk($sformatf("mul_c%0d", c), strb(), exp_s);
            if (c >= 1 && c <= 3)
                chk($sformatf("mul_rdk%0d", c), {rd_a_idx, rd_b_idx, rd_k},
                    {2'd0, 2'd1, 8'(c - 1)});
            if (c >= 23 && c <= 24)
                chk($sformatf("mul_row%0d", c), acc_row, 8'(c - 23));
            // A stray multiply during FEED must not disturb the schedule
            if (c == 1) multiply = 1'b1;
            tick();
            multiply = 1'b0;
            c++;
        end
        chk("mul_len", c, 26);
        chk("mul_err", ctrl_error, 8'h00);

        // A0 (3 cols) x B2 (never loaded) -> dimension error
        buffer_a_idx = 5'd0;
        buffer_b_idx = 5'd2;
        multiply = 1'b1;
        tick();
        multiply = 1'b0;
        chk("bad_err", ctrl_error, 8'h02);
        chk("bad_strb", strb(), 6'b100000);
        tick();
        chk("bad_hold", {strb(), ctrl_error}, {6'b100000, 8'h02});

        // load + multiply together: the load to A slot 2 (1x1) wins
        buffer_a_idx = 5'd2;
        buffer_b_idx = 5'd1;
        multiply = 1'b1;
        start_load(1'b0, 5'd2, 8'd1, 8'd1);
        multiply = 1'b0;
        chk("both_err", ctrl_error, 8'h00);
        stream("both", 1'b0, 2'd2, 1, 1, 1'b0);

        // Empty load (dim_x=0) stays in IDLE
        start_load(1'b1, 5'd3, 8'd0, 8'd5);
        chk("empty_ld", strb(), 6'b100000);

        // Reset during DRAIN clears everything, including slot dims
        buffer_a_idx = 5'd0;
        buffer_b_idx = 5'd1;
        multiply = 1'b1;
        tick();
        multiply = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("pre_rst", strb(), 6'b000000);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {strb(), ctrl_error}, {6'b100000, 8'h00});
        #1 rst = 1'b0;
        tick();
        multiply = 1'b1;
        tick();
        multiply = 1'b0;
        chk("rst_dims", {strb(), ctrl_error}, {6'b100000, 8'h02});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
